// File: rtl/vga_tile_renderer_if.sv
// ---------------------------------------------------------------------------
// vga_tile_renderer_if
//   Signal bundle between the tile renderer and its three neighbours: the VGA
//   timing generator (valid/x_ptr/y_ptr/frame_start), the game CPU (palette
//   write port and display mode bits), the external synchronous map RAM
//   (tile_addr/tile_state) and the DAC pins (RGB/rgb_valid).
//
//   modport slave  : the renderer itself
//   modport master : everything around it (timing gen, CPU, map RAM, DAC)
// ---------------------------------------------------------------------------
interface vga_tile_if #(
  parameter int ADDR_W  = 11,
  parameter int STATE_W = 3
);
  // Timing generator
  logic               valid;
  logic [9:0]         x_ptr;
  logic [9:0]         y_ptr;
  logic               frame_start;
  // Map RAM
  logic [ADDR_W-1:0]  tile_addr;
  logic [STATE_W-1:0] tile_state;
  // CPU palette port and display modes
  logic               pal_we;
  logic [STATE_W-1:0] pal_idx;
  logic [11:0]        pal_data;
  logic               grid_en;
  logic               blink_en;
  // DAC side
  logic [11:0]        RGB;
  logic               rgb_valid;

  modport slave (
    input  valid, x_ptr, y_ptr, frame_start,
    input  tile_state,
    input  pal_we, pal_idx, pal_data, grid_en, blink_en,
    output tile_addr, RGB, rgb_valid
  );

  modport master (
    output valid, x_ptr, y_ptr, frame_start,
    output tile_state,
    output pal_we, pal_idx, pal_data, grid_en, blink_en,
    input  tile_addr, RGB, rgb_valid
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// ---------------------------------------------------------------------------
// vga_tile_renderer
//   Colours the visible VGA raster from a tile map. Each scan coordinate is
//   mapped to a (2**CELL_LOG2)-pixel square cell, the cell state is fetched
//   from an external synchronous map RAM and looked up in a CPU-writable
//   palette. Optional grid lines on cell offset 0 and a frame-rate blink of
//   one palette index are layered on top.
//
//   Pipeline (one pixel per clock, no stalls, valid -> rgb_valid = 3 cycles):
//     p0 : qualify pixel, register map address and grid flag
//     p1 : map RAM returns tile_state while valid/grid flag wait alongside
//     p2 : palette lookup and colour select, registered onto RGB
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   bus (slave)  valid, x_ptr, y_ptr, frame_start  <- timing generator
//                tile_addr -> / tile_state <-      map RAM
//                pal_we, pal_idx, pal_data         <- CPU palette write
//                grid_en, blink_en                 <- display modes
//                RGB, rgb_valid ->                 DAC
// ---------------------------------------------------------------------------
module vga_tile_renderer #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          CELL_LOG2  = 4,
  parameter int          STATE_W    = 3,
  parameter int          ADDR_W     = 11,
  parameter int          BLINK_IDX  = 3,
  parameter int          BLINK_LOG2 = 5,
  parameter logic [11:0] GRID_RGB   = 12'h333
) (
  input  logic    clk,
  input  logic    rst,
  vga_tile_if.slave bus
);

  localparam int COLS  = H_ACTIVE >> CELL_LOG2;
  localparam int PAL_N = 2 ** STATE_W;

  // Power-on palette; entries beyond the eight named colours start black.
  function automatic logic [11:0] pal_default(input int idx);
    case (idx)
      0:       pal_default = 12'h000;
      1:       pal_default = 12'hFFF;
      2:       pal_default = 12'h0F0;
      3:       pal_default = 12'hF00;
      4:       pal_default = 12'h00F;
      5:       pal_default = 12'hFF0;
      6:       pal_default = 12'h0FF;
      7:       pal_default = 12'hF0F;
      default: pal_default = 12'h000;
    endcase
  endfunction

  // Output colour priority: blanking, then grid, then blink-off, then palette.
  function automatic logic [11:0] pick_colour(
    input logic        vld,
    input logic        grid_hit,
    input logic        blink_hit,
    input logic [11:0] pal_state,
    input logic [11:0] pal_zero
  );
    if (!vld)           pick_colour = 12'h000;
    else if (grid_hit)  pick_colour = GRID_RGB;
    else if (blink_hit) pick_colour = pal_zero;
    else                pick_colour = pal_state;
  endfunction

  // Control state
  logic                  vld_p0;
  logic                  vld_p1;
  logic                  rgb_valid_q;
  logic [BLINK_LOG2-1:0] blink_q;
  logic [BLINK_LOG2-1:0] blink_d;

  // Datapath state
  logic [ADDR_W-1:0]     tile_addr_q;
  logic [ADDR_W-1:0]     tile_addr_d;
  logic                  on_grid_p0;
  logic                  on_grid_p1;
  logic [11:0]           rgb_q;
  logic [11:0]           rgb_d;
  logic [11:0]           pal_q [PAL_N];

  // Stage-0 combinational terms
  logic                  v0_s;
  logic                  on_grid_s;
  logic [9:0]            row_s;
  logic [9:0]            col_s;

  // Stage-2 combinational terms
  logic                  grid_hit_s;
  logic                  blink_hit_s;

  // ---- stage p0: qualify coordinate, form map address --------------------
  // Coordinates outside the visible window are dropped even when the timing
  // generator flags them valid, and the RAM address is left where it was.
  assign v0_s      = bus.valid
                   && (32'(bus.x_ptr) < H_ACTIVE)
                   && (32'(bus.y_ptr) < V_ACTIVE);
  assign row_s     = bus.y_ptr >> CELL_LOG2;
  assign col_s     = bus.x_ptr >> CELL_LOG2;
  assign on_grid_s = (bus.x_ptr[CELL_LOG2-1:0] == '0)
                   || (bus.y_ptr[CELL_LOG2-1:0] == '0);

  always_comb begin
    tile_addr_d = tile_addr_q;
    if (v0_s) begin
      tile_addr_d = ADDR_W'(row_s) * ADDR_W'(COLS) + ADDR_W'(col_s);
    end
  end

  // Blink counter advances once per frame; its MSB gives a 50% duty phase.
  always_comb begin
    blink_d = blink_q;
    if (bus.frame_start) begin
      blink_d = blink_q + 1'b1;
    end
  end

  // ---- stage p2: palette lookup aligned with tile_state from the RAM -----
  // tile_state is valid in the same cycle as vld_p1/on_grid_p1: the RAM
  // registered the address presented during p1.
  assign grid_hit_s  = bus.grid_en && on_grid_p1;
  assign blink_hit_s = (bus.tile_state == STATE_W'(BLINK_IDX))
                     && bus.blink_en
                     && blink_q[BLINK_LOG2-1];

  // The palette array is read here combinationally before any same-cycle
  // write lands, so a write and a read of one index returns the old entry.
  assign rgb_d = pick_colour(vld_p1, grid_hit_s, blink_hit_s,
                             pal_q[bus.tile_state], pal_q[0]);

  // ---- registers: control with reset -------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      rgb_valid_q <= 1'b0;
      blink_q     <= '0;
      tile_addr_q <= '0;
      rgb_q       <= 12'h000;
    end else begin
      vld_p0      <= v0_s;
      vld_p1      <= vld_p0;
      rgb_valid_q <= vld_p1;
      blink_q     <= blink_d;
      tile_addr_q <= tile_addr_d;
      rgb_q       <= rgb_d;
    end
  end

  // ---- registers: grid flag travels with the pixel, no reset needed ------
  always_ff @(posedge clk) begin
    on_grid_p0 <= on_grid_s;
    on_grid_p1 <= on_grid_p0;
  end

  // ---- palette: reset restores defaults, CPU must rewrite afterwards -----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else if (bus.pal_we) begin
      pal_q[bus.pal_idx] <= bus.pal_data;
    end
  end

  assign bus.tile_addr = tile_addr_q;
  assign bus.RGB       = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_tile_if #(.ADDR_W(11), .STATE_W(3)) bus ();

  vga_tile_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous map RAM model: data valid one cycle after the address.
  logic [2:0] map_mem [2048];
  always @(posedge clk) bus.tile_state <= map_mem[bus.tile_addr];

  int total = 0;
  int bad   = 0;

  // Scoreboard: {rgb_valid, RGB} expected per driven cycle.
  logic [12:0] exp_q [$];

  typedef struct {
    int         x;
    int         y;
    bit         v;
    bit         grid;
    logic [2:0] st;
    bit         exp_v;
    logic [11:0] exp_rgb;
    int         exp_addr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Drive one cycle; the output seen after this edge belongs to the pixel
  // driven two ticks earlier (3-cycle latency, queue keeps 2 in flight).
  task automatic tick(input logic ev, input logic [11:0] er);
    logic [12:0] e;
    exp_q.push_back({ev, er});
    @(posedge clk);
    #1;
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check("pixel", {19'b0, bus.rgb_valid, bus.RGB}, {19'b0, e});
    end
  endtask

  task automatic drive_px(input int x, input int y, input logic ev, input logic [11:0] er);
    bus.x_ptr = 10'(x);
    bus.y_ptr = 10'(y);
    bus.valid = 1'b1;
    tick(ev, er);
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0;
    for (int k = 0; k < n; k++) tick(1'b0, 12'h000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          x    y   v grid st  ev  rgb      addr
    vecs[0]  = '{300, 200, 1, 0, 3'd0, 1, 12'h000, 498};
    vecs[1]  = '{17,  17,  1, 0, 3'd2, 1, 12'h0F0, 41};
    vecs[2]  = '{16,  17,  1, 1, 3'd2, 1, 12'h333, 41};
    vecs[3]  = '{16,  17,  1, 0, 3'd2, 1, 12'h0F0, 41};
    vecs[4]  = '{17,  32,  1, 1, 3'd2, 1, 12'h333, 81};
    vecs[5]  = '{33,  33,  1, 1, 3'd1, 1, 12'hFFF, 82};
    vecs[6]  = '{639, 479, 1, 0, 3'd7, 1, 12'hF0F, 1199};
    vecs[7]  = '{640, 10,  1, 0, 3'd1, 0, 12'h000, 1199};
    vecs[8]  = '{5,   480, 1, 0, 3'd1, 0, 12'h000, 1199};
    vecs[9]  = '{100, 100, 0, 0, 3'd1, 0, 12'h000, 1199};
    vecs[10] = '{50,  70,  1, 0, 3'd4, 1, 12'h00F, 163};
    vecs[11] = '{200, 150, 1, 0, 3'd5, 1, 12'hFF0, 372};
    vecs[12] = '{210, 150, 1, 0, 3'd6, 1, 12'h0FF, 373};
    vecs[13] = '{0,   0,   1, 1, 3'd3, 1, 12'h333, 0};
    vecs[14] = '{3,   5,   1, 1, 3'd3, 1, 12'hF00, 0};

    for (int i = 0; i < 2048; i++) map_mem[i] = 3'd0;
    bus.valid       = 1'b0;
    bus.x_ptr       = '0;
    bus.y_ptr       = '0;
    bus.frame_start = 1'b0;
    bus.pal_we      = 1'b0;
    bus.pal_idx     = '0;
    bus.pal_data    = '0;
    bus.grid_en     = 1'b0;
    bus.blink_en    = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'(bus.RGB), 32'h0);
    check("rst_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    check("rst_tile_addr", 32'(bus.tile_addr), 32'h0);
    rst = 1'b0;
    exp_q.push_back(13'h0);
    exp_q.push_back(13'h0);

    // Table-driven single pixels, each flushed before the next
    for (int i = 0; i < 15; i++) begin
      bus.grid_en  = vecs[i].grid;
      bus.blink_en = 1'b0;
      if (vecs[i].exp_v) map_mem[vecs[i].exp_addr] = vecs[i].st;
      bus.x_ptr = 10'(vecs[i].x);
      bus.y_ptr = 10'(vecs[i].y);
      bus.valid = vecs[i].v;
      tick(vecs[i].exp_v, vecs[i].exp_rgb);
      check($sformatf("tile_addr_%0d", i), 32'(bus.tile_addr), 32'(vecs[i].exp_addr));
      idle(2);
    end
    bus.grid_en = 1'b0;

    // Palette write colliding with a read of the same index
    drive_px(17, 17, 1'b1, 12'h0F0);
    idle(1);
    bus.pal_we   = 1'b1;
    bus.pal_idx  = 3'd2;
    bus.pal_data = 12'hABC;
    idle(1);
    bus.pal_we   = 1'b0;
    drive_px(17, 17, 1'b1, 12'hABC);
    idle(2);

    // Blinking of index 3 across 34 frames (wraps after 32)
    for (int f = 0; f < 34; f++) begin
      bus.blink_en = 1'b1;
      drive_px(3, 5, 1'b1, ((f % 32) >= 16) ? 12'h000 : 12'hF00);
      idle(2);
      if (f == 20) begin
        bus.blink_en = 1'b0;
        drive_px(3, 5, 1'b1, 12'hF00);
        idle(2);
        bus.blink_en = 1'b1;
        drive_px(17, 17, 1'b1, 12'hABC);
        idle(2);
      end
      bus.frame_start = 1'b1;
      idle(1);
      bus.frame_start = 1'b0;
    end
    bus.blink_en = 1'b0;

    // Reset while pixels are streaming
    drive_px(17, 17, 1'b1, 12'hABC);
    drive_px(18, 17, 1'b1, 12'hABC);
    drive_px(19, 17, 1'b1, 12'hABC);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    check("midrst_rgb", 32'(bus.RGB), 32'h0);
    check("midrst_tile_addr", 32'(bus.tile_addr), 32'h0);
    rst = 1'b0;
    bus.valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(13'h0);
    exp_q.push_back(13'h0);
    drive_px(17, 17, 1'b1, 12'h0F0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
